ram_scan_display: RTL and testbench

//  Parametrised dual-port RAM with a self-scanning read side for board-level memory inspection.

---
 rtl/ram_scan_pkg.sv | 10 +
 rtl/ram_scan_display_addr_bcd_conv.sv | 27 ++
 rtl/ram_scan_display.sv | 87 ++++++++
 tb/tb_ram_scan_display.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/ram_scan_pkg.sv
// Shared types for the RAM scan/inspection block: read-side mode encoding and BCD digit type.
package ram_scan_pkg;

  typedef enum logic {SCAN = 1'b0, MANUAL = 1'b1} scan_mode_t;

  typedef logic [3:0] bcd_digit_t;

  localparam int BCD_DIGITS = 3;

endpackage

// File: rtl/ram_scan_display_addr_bcd_conv.sv
// Combinational double-dabble: ADDR_W-bit binary address to three packed BCD digits {hundreds, tens, ones}.
module addr_bcd_conv
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic [ADDR_W-1:0]         bin,
  output logic [4*BCD_DIGITS-1:0]   bcd
);

  always_comb begin
    logic [4*BCD_DIGITS-1:0] acc;
    bcd_digit_t              dig;
    acc = '0;
    dig = '0;
    for (int i = ADDR_W - 1; i >= 0; i--) begin
      // Add-3 correction on every digit before each shift keeps each nibble decimal.
      for (int d = 0; d < BCD_DIGITS; d++) begin
        dig = acc[4*d +: 4];
        if (dig >= 4'd5) acc[4*d +: 4] = dig + 4'd3;
      end
      acc = {acc[4*BCD_DIGITS-2:0], bin[i]};
    end
    bcd = acc;
  end

endmodule

// File: rtl/ram_scan_display.sv
// Dual-port RAM with self-scanning or manual read side, registered read data and BCD address digits.
// Define RAM_SCAN_RDW_BYPASS_EN to forward same-cycle write data to the read port.
module ram_scan_display
  import ram_scan_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 3,
  parameter int SCAN_DIV = 50_000_000
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     wren,
  input  logic [ADDR_W-1:0]        wraddress,
  input  logic [DATA_W-1:0]        data,
  input  logic                     mode,
  input  logic [ADDR_W-1:0]        man_addr,
  output logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        q,
  output logic                     rd_valid,
  output logic                     step,
  output logic [4*BCD_DIGITS-1:0]  addr_bcd
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int PS_W  = $clog2(SCAN_DIV);

  logic [DATA_W-1:0]       mem [DEPTH];
  logic [PS_W-1:0]         prescaler;
  logic [ADDR_W-1:0]       scan_addr;
  logic [ADDR_W-1:0]       sel_addr;
  logic [DATA_W-1:0]       rd_word;
  logic [4*BCD_DIGITS-1:0] bcd_next;
  logic                    tick;
  scan_mode_t              cur_mode;

  assign cur_mode = scan_mode_t'(mode);
  assign tick     = (cur_mode == SCAN) && (prescaler == PS_W'(SCAN_DIV - 1));
  assign sel_addr = (cur_mode == MANUAL) ? man_addr : scan_addr;

  // No reset on the array so it maps onto block RAM and survives reset.
  always_ff @(posedge clock) begin
    if (wren) mem[wraddress] <= data;
  end

`ifdef RAM_SCAN_RDW_BYPASS_EN
  assign rd_word = (wren && (wraddress == sel_addr)) ? data : mem[sel_addr];
`else
  assign rd_word = mem[sel_addr];
`endif

  // MANUAL parks the prescaler at 0 so returning to SCAN gets a full period.
  always_ff @(posedge clock) begin
    if (reset) begin
      prescaler <= '0;
      scan_addr <= '0;
    end else if (cur_mode == MANUAL) begin
      prescaler <= '0;
    end else if (tick) begin
      prescaler <= '0;
      scan_addr <= scan_addr + 1'b1;
    end else begin
      prescaler <= prescaler + 1'b1;
    end
  end

  addr_bcd_conv #(.ADDR_W(ADDR_W)) u_bcd (
    .bin (sel_addr),
    .bcd (bcd_next)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_addr  <= '0;
      q        <= '0;
      rd_valid <= 1'b0;
      step     <= 1'b0;
      addr_bcd <= '0;
    end else begin
      rd_addr  <= sel_addr;
      q        <= rd_word;
      rd_valid <= 1'b1;
      step     <= tick;
      addr_bcd <= bcd_next;
    end
  end

endmodule

// File: tb/tb_ram_scan_display.sv
// Bench for ram_scan_display: small 8x3 instance under directed and random stimulus plus a 9-bit address instance for BCD range.
module tb_ram_scan_display;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 3;
  localparam int SCAN_DIV = 4;
  localparam int DEPTH    = 8;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic              wren = 1'b0;
  logic [ADDR_W-1:0] wraddress = '0;
  logic [DATA_W-1:0] data = '0;
  logic              mode = 1'b1;
  logic [ADDR_W-1:0] man_addr = '0;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] q;
  logic              rd_valid;
  logic              step;
  logic [11:0]       addr_bcd;

  logic [8:0]  man_addr2 = '0;
  logic [8:0]  rd_addr2;
  logic [2:0]  q2;
  logic        rd_valid2;
  logic        step2;
  logic [11:0] addr_bcd2;

  ram_scan_display #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clock     (clk),
    .reset     (reset),
    .wren      (wren),
    .wraddress (wraddress),
    .data      (data),
    .mode      (mode),
    .man_addr  (man_addr),
    .rd_addr   (rd_addr),
    .q         (q),
    .rd_valid  (rd_valid),
    .step      (step),
    .addr_bcd  (addr_bcd)
  );

  ram_scan_display #(.ADDR_W(9), .DATA_W(3), .SCAN_DIV(SCAN_DIV)) dut9 (
    .clock     (clk),
    .reset     (reset),
    .wren      (1'b0),
    .wraddress (9'd0),
    .data      (3'd0),
    .mode      (1'b1),
    .man_addr  (man_addr2),
    .rd_addr   (rd_addr2),
    .q         (q2),
    .rd_valid  (rd_valid2),
    .step      (step2),
    .addr_bcd  (addr_bcd2)
  );

  // reference model
  typedef struct packed {
    logic [2:0]  rd_addr;
    logic [2:0]  q;
    logic        q_known;
    logic        rd_valid;
    logic        step;
    logic [11:0] bcd;
    logic [11:0] bcd2;
  } exp_t;

  exp_t exp_q[$];

  logic [2:0] m_mem [DEPTH];
  bit         m_known [DEPTH];
  int         m_scan = 0;
  int         m_phase = 0;
  int         tests = 0;
  int         failed = 0;

  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Predict the outputs visible after the coming edge from the inputs now applied.
  task automatic model_push();
    exp_t e;
    int   sel;
    bit   tick;
    e = '0;
    e.q_known = 1'b1;
    sel = mode ? int'(man_addr) : m_scan;
    if (reset) begin
      m_scan  = 0;
      m_phase = 0;
    end else begin
      tick       = (mode == 1'b0) && (m_phase == SCAN_DIV - 1);
      e.rd_addr  = 3'(sel);
      e.q        = m_mem[sel];
      e.q_known  = m_known[sel];
`ifdef RAM_SCAN_RDW_BYPASS_EN
      if (wren && int'(wraddress) == sel) begin
        e.q       = data;
        e.q_known = 1'b1;
      end
`endif
      e.rd_valid = 1'b1;
      e.step     = tick;
      e.bcd      = to_bcd(sel);
      e.bcd2     = to_bcd(int'(man_addr2));
      m_phase    = mode ? 0 : (m_phase + 1) % SCAN_DIV;
      if (tick) m_scan = (m_scan + 1) % DEPTH;
    end
    if (wren) begin
      m_mem[wraddress]   = data;
      m_known[wraddress] = 1'b1;
    end
    exp_q.push_back(e);
  endtask

  // driver tasks
  task automatic cyc();
    model_push();
    @(negedge clk);
  endtask

  task automatic idle(int n);
    wren = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic scan_until(int addr);
    int guard;
    guard = 0;
    mode = 1'b0;
    wren = 1'b0;
    while (m_scan != addr && guard < 200) begin
      cyc();
      guard++;
    end
    tests++;
    if (m_scan != addr) begin
      failed++;
      $display("FAIL scan_until: model at %0d required %0d", m_scan, addr);
    end
  endtask

  // scoreboard monitor
  task automatic check(string name, logic [11:0] act, logic [11:0] req);
    tests++;
    if (act !== req) begin
      failed++;
      $display("FAIL %s at %0t: got %0h required %0h", name, $time, act, req);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("rd_addr", 12'(rd_addr), 12'(e.rd_addr));
        if (e.q_known) check("q", 12'(q), 12'(e.q));
        check("rd_valid", 12'(rd_valid), 12'(e.rd_valid));
        check("step", 12'(step), 12'(e.step));
        check("addr_bcd", addr_bcd, e.bcd);
        check("addr_bcd9", addr_bcd2, e.bcd2);
      end
    end
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) m_known[i] = 1'b0;

    // reset held two cycles, then release
    reset = 1'b1;
    mode = 1'b1;
    man_addr = 3'd0;
    idle(2);
    reset = 1'b0;
    idle(2);

    // fill memory with i ^ 5, then scan a full lap
    for (int i = 0; i < DEPTH; i++) begin
      wren = 1'b1;
      wraddress = 3'(i);
      data = 3'(i) ^ 3'b101;
      cyc();
    end
    wren = 1'b0;
    mode = 1'b0;
    idle(SCAN_DIV * DEPTH + 6);

    // SCAN -> MANUAL at address 5, back to SCAN after 10 cycles
    scan_until(5);
    mode = 1'b1;
    man_addr = 3'd2;
    idle(10);
    mode = 1'b0;
    idle(SCAN_DIV + 3);

    // read-during-write at the displayed manual address
    mode = 1'b1;
    man_addr = 3'd3;
    wren = 1'b1; wraddress = 3'd3; data = 3'd6;
    cyc();
    idle(2);
    wren = 1'b1; wraddress = 3'd3; data = 3'd1;
    cyc();
    idle(3);

    // reset mid-scan at address 6; RAM keeps its data
    scan_until(6);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    idle(SCAN_DIV * 2);

    // BCD range on the 9-bit instance
    man_addr2 = 9'd511;
    idle(2);
    man_addr2 = 9'd0;
    idle(2);
    man_addr2 = 9'd99;
    idle(1);
    man_addr2 = 9'd100;
    idle(1);

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      reset = ($urandom_range(99) == 0);
      if ($urandom_range(19) == 0) mode = ~mode;
      wren = ($urandom_range(2) == 0);
      wraddress = 3'($urandom_range(7));
      data = 3'($urandom_range(7));
      if ($urandom_range(3) == 0) man_addr = 3'($urandom_range(7));
      if ($urandom_range(7) == 0) wraddress = mode ? man_addr : 3'(m_scan);
      man_addr2 = 9'($urandom_range(511));
      cyc();
    end
    reset = 1'b0;
    idle(3);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
